// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU types and constants for the instruction fetch path.
package cpu_pkg;

  localparam int XLEN = 32;

  // Fetch PC loaded out of reset unless the instantiating core overrides it.
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response channel plus the decode-side stream.
// master = the fetch unit, slave = memory and decode together.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO of fetch entries. The head is read straight from the
// storage registers, so a pushed entry is visible the cycle after the push.
// flush empties the FIFO in one cycle and overrides push/pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  fetch_entry_t                wdata,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output fetch_entry_t                head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_fifo: DEPTH must be a power of two and at least 2");
  end

  assign do_push = push & ~flush & (count != FULL);
  assign do_pop  = pop  & ~flush & (count != '0);

  // Storage; cleared on reset so the head fields read zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch side of the instruction address path: owns the fetch PC, issues
// word requests to instruction memory under a credit limit, tags in-order
// responses with their PC, buffers them and streams {pc, instr} to decode.
// A redirect flushes the buffer and marks every surviving in-flight request
// stale so its response is dropped on arrival.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] PC_INC   = 32'd1,
  parameter int              DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  instr_fetch_unit_if.master   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  fetch_entry_t    wdata;
  fetch_entry_t    head;

  // Every request in flight or sitting in the buffer holds one slot, so a
  // response can always be pushed without checking for room.
  assign credit_used = {1'b0, outstanding} + {1'b0, count};

  assign bus.imem_req_valid = ~rst & fetch_en & ~redirect_valid & (credit_used < DEPTH_W);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;

  // A response with nothing outstanding is a memory protocol error; ignore
  // it rather than wrap the counter.
  assign rsp_take = bus.imem_rsp_valid & (outstanding != '0);
  assign push     = rsp_take & ~redirect_valid & (discard == '0);
  assign pop      = bus.out_valid & bus.out_ready & ~redirect_valid;
  assign wdata    = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  // Fetch PC: redirect wins, otherwise advance on each accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + PC_INC;
    end
  end

  // Response PC tag: tracks the PC of the next response that will be kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      rsp_pc <= redirect_pc;
    end else if (push) begin
      rsp_pc <= rsp_pc + PC_INC;
    end
  end

  // Outstanding requests; no issue happens on a redirect cycle so req_fire
  // is already zero there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
    end
  end

  // Stale-response counter: on redirect everything still in flight after
  // this cycle is stale; afterwards each dropped response retires one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard <= '0;
    end else if (redirect_valid) begin
      discard <= outstanding - CW'(rsp_take);
    end else if (rsp_take && (discard != '0)) begin
      discard <= discard - 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> (outstanding != '0));

  a_discard_bounded: assert property (@(posedge clk) disable iff (rst)
    discard <= outstanding);

  a_credit_bounded: assert property (@(posedge clk) disable iff (rst)
    credit_used <= DEPTH_W);

endmodule
